// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//   Hazard and bypass controller for the in-order pipeline. A shadow pipeline
//   of in-flight register writers (valid, rd, is_load) shifts one entry per
//   cycle. The ID-stage sources are matched against it to produce a stall,
//   per-operand bypass selects, an issue strobe and a saturating stall counter.
//   Build option: define PIPE_FWD_EN to enable bypassing. Without it, every
//   pending writer of a source stalls ID and operands come from the regfile.
module pipe_hazard_scoreboard #(
   parameter int REG_AW      = 5,
   parameter int DEPTH       = 3,
   parameter int LOAD_READY  = 1,
   parameter int KILL_STAGES = 1,
   parameter int CNT_W       = 16,
   localparam int FWD_W      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic              id_rs_used,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rt_used,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              flush,
   output logic              stall,
   output logic              issue,
   output logic [FWD_W-1:0]  fwd_rs_sel,
   output logic [FWD_W-1:0]  fwd_rt_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DEPTH-1:0]  sh_valid;
   logic [DEPTH-1:0]  sh_load;
   logic [REG_AW-1:0] sh_rd [DEPTH];

   logic rs_hit, rt_hit;
   logic rs_lu, rt_lu;
   logic stall_cond;
`ifdef PIPE_FWD_EN
   logic [FWD_W-1:0] rs_sel, rt_sel;
`endif

   // Youngest-match search: scanning oldest to youngest lets the lowest index win.
   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      rs_lu  = 1'b0;
      rt_lu  = 1'b0;
`ifdef PIPE_FWD_EN
      rs_sel = '0;
      rt_sel = '0;
`endif
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (id_rs_used && (id_rs != '0) && sh_valid[k] && (sh_rd[k] == id_rs)) begin
            rs_hit = 1'b1;
            rs_lu  = sh_load[k] && (k < LOAD_READY);
`ifdef PIPE_FWD_EN
            rs_sel = FWD_W'(k + 1);
`endif
         end
         if (id_rt_used && (id_rt != '0) && sh_valid[k] && (sh_rd[k] == id_rt)) begin
            rt_hit = 1'b1;
            rt_lu  = sh_load[k] && (k < LOAD_READY);
`ifdef PIPE_FWD_EN
            rt_sel = FWD_W'(k + 1);
`endif
         end
      end
   end

   // Stall condition and bypass selects; a load-use hit is always also a plain hit.
   always_comb begin
`ifdef PIPE_FWD_EN
      stall_cond = (rs_hit & rs_lu) | (rt_hit & rt_lu);
      fwd_rs_sel = rs_sel;
      fwd_rt_sel = rt_sel;
`else
      stall_cond = rs_hit | rt_hit | rs_lu | rt_lu;
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
`endif
      stall = id_valid & ~flush & stall_cond;
      issue = id_valid & ~stall & ~flush;
   end

   // Shadow pipeline shifts every cycle; flush kills the young entries only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_valid <= '0;
         sh_load  <= '0;
         for (int k = 0; k < DEPTH; k++) sh_rd[k] <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            sh_valid[k] <= sh_valid[k-1] && !(flush && (k < KILL_STAGES));
            sh_load[k]  <= sh_load[k-1];
            sh_rd[k]    <= sh_rd[k-1];
         end
         sh_valid[0] <= issue & id_wr_en & (id_rd != '0);
         sh_load[0]  <= id_is_load;
         sh_rd[0]    <= id_rd;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard
//   Directed scenarios followed by random traffic. Expected outputs come from a
//   list of issued writers tagged with their issue cycle: a writer's shadow
//   index is its age, and a flush kills writers that are too young.
module tb_pipe_hazard_scoreboard;

   localparam int REG_AW      = 5;
   localparam int DEPTH       = 3;
   localparam int LOAD_READY  = 1;
   localparam int KILL_STAGES = 1;
   localparam int CNT_W       = 4;
   localparam int FWD_W       = $clog2(DEPTH + 1);
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic              clk, rst_n;
   logic              id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              stall, issue;
   logic [FWD_W-1:0]  fwd_rs_sel, fwd_rt_sel;
   logic [CNT_W-1:0]  stall_cnt;

   pipe_hazard_scoreboard #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY),
      .KILL_STAGES(KILL_STAGES), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
      .stall(stall), .issue(issue), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          t;
      logic [4:0]  rd;
      bit          ld;
      bit          dead;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  m_cnt = 0;
   int  checks = 0;
   int  failures = 0;

   logic             obs_stall, obs_issue;
   logic [FWD_W-1:0] obs_rs, obs_rt;
   logic [CNT_W-1:0] obs_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Youngest live writer of src: index = age in cycles since it left ID, minus one.
   task automatic lookup(input logic [4:0] src, input logic used, output int k_hit, output bit ld);
      k_hit = -1;
      ld    = 1'b0;
      if (used && src != 0) begin
         foreach (wq[i]) begin
            int k;
            k = cyc - wq[i].t - 1;
            if (!wq[i].dead && k >= 0 && k < DEPTH && wq[i].rd == src && (k_hit < 0 || k < k_hit)) begin
               k_hit = k;
               ld    = wq[i].ld;
            end
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic we,
                        input logic [4:0] rd, input logic ld, input logic fl);
      int  ks, kt;
      bit  ls, lt, haz;
      logic e_stall, e_issue;
      int  e_rs, e_rt;
      id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_wr_en = we; id_rd = rd; id_is_load = ld; flush = fl;
      #1;
      lookup(rs, rsu, ks, ls);
      lookup(rt, rtu, kt, lt);
`ifdef PIPE_FWD_EN
      haz  = (ks >= 0 && ls && ks < LOAD_READY) || (kt >= 0 && lt && kt < LOAD_READY);
      e_rs = ks + 1;
      e_rt = kt + 1;
`else
      haz  = (ks >= 0) || (kt >= 0);
      e_rs = 0;
      e_rt = 0;
`endif
      e_stall = v && !fl && haz;
      e_issue = v && !fl && !e_stall;
      obs_stall = stall; obs_issue = issue; obs_rs = fwd_rs_sel; obs_rt = fwd_rt_sel; obs_cnt = stall_cnt;
      chk("stall", stall, e_stall);
      chk("issue", issue, e_issue);
      chk("fwd_rs_sel", fwd_rs_sel, e_rs);
      chk("fwd_rt_sel", fwd_rt_sel, e_rt);
      chk("stall_cnt", stall_cnt, m_cnt);
      @(posedge clk);
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      if (fl) foreach (wq[i]) if (cyc - wq[i].t < KILL_STAGES) wq[i].dead = 1'b1;
      if (e_issue && we && rd != 0) wq.push_back('{cyc, rd, ld, 1'b0});
      cyc++;
      while (wq.size() > 0 && cyc - wq[0].t - 1 >= DEPTH) void'(wq.pop_front());
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      id_valid = 1'b0; id_rs = '0; id_rs_used = 1'b0; id_rt = '0; id_rt_used = 1'b0;
      id_wr_en = 1'b0; id_rd = '0; id_is_load = 1'b0; flush = 1'b0;
      #2;
      chk("reset_cnt", stall_cnt, 0);
      chk("reset_stall", stall, 0);
      chk("reset_issue", issue, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef PIPE_FWD_EN
      // add r3, then two readers of r3
      cycle(1, 0, 0, 0, 0, 1, 3, 0, 0);
      cycle(1, 3, 1, 0, 0, 0, 0, 0, 0);
      chk("raw_fwd1", obs_rs, 1);
      cycle(1, 3, 1, 0, 0, 0, 0, 0, 0);
      chk("raw_fwd2", obs_rs, 2);
      // lw r4, reader stalls once, retry bypasses from MEM
      cycle(1, 0, 0, 0, 0, 1, 4, 1, 0);
      cycle(1, 0, 0, 4, 1, 0, 0, 0, 0);
      chk("lu_stall", obs_stall, 1);
      cycle(1, 0, 0, 4, 1, 0, 0, 0, 0);
      chk("lu_retry_stall", obs_stall, 0);
      chk("lu_retry_fwd", obs_rt, 2);
      chk("lu_cnt", obs_cnt, 1);
      // WAW: newest writer wins
      cycle(1, 0, 0, 0, 0, 1, 5, 0, 0);
      cycle(1, 0, 0, 0, 0, 1, 5, 0, 0);
      cycle(1, 5, 1, 0, 0, 0, 0, 0, 0);
      chk("waw_fwd", obs_rs, 1);
      // lw r6, then flush with a load-use reader in ID
      cycle(1, 0, 0, 0, 0, 1, 6, 1, 0);
      cycle(1, 0, 0, 6, 1, 0, 0, 0, 1);
      chk("flush_stall", obs_stall, 0);
      chk("flush_issue", obs_issue, 0);
      cycle(1, 0, 0, 6, 1, 0, 0, 0, 0);
      chk("flush_survivor", obs_rt, (KILL_STAGES >= 2) ? 0 : 2);
`else
      // add r7, reader waits until the writer retires
      cycle(1, 0, 0, 0, 0, 1, 7, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 7, 1, 0, 0, 0, 0, 0, 0);
         chk("nofwd_stall", obs_stall, 1);
      end
      cycle(1, 7, 1, 0, 0, 0, 0, 0, 0);
      chk("nofwd_release", obs_stall, 0);
      chk("nofwd_fwd", obs_rs, 0);
      chk("nofwd_cnt", obs_cnt, 3);
      // flush overrides a pending hazard
      cycle(1, 0, 0, 0, 0, 1, 6, 1, 0);
      cycle(1, 0, 0, 6, 1, 0, 0, 0, 1);
      chk("flush_stall", obs_stall, 0);
      chk("flush_issue", obs_issue, 0);
      cycle(1, 0, 0, 6, 1, 0, 0, 0, 0);
      chk("flush_survivor", obs_stall, (KILL_STAGES >= 2) ? 0 : 1);
      idle();
      idle();
`endif
      // reg 0 never matches
      cycle(1, 0, 0, 0, 0, 1, 0, 1, 0);
      cycle(1, 0, 1, 0, 1, 0, 0, 0, 0);
      chk("r0_stall", obs_stall, 0);

      // reset with three writers in flight
      cycle(1, 0, 0, 0, 0, 1, 10, 1, 0);
      cycle(1, 0, 0, 0, 0, 1, 11, 0, 0);
      cycle(1, 0, 0, 0, 0, 1, 12, 1, 0);
      rst_n = 1'b0;
      id_valid = 1'b1; id_rs = 5'd12; id_rs_used = 1'b1; id_rt = 5'd11; id_rt_used = 1'b1;
      id_wr_en = 1'b0; flush = 1'b0;
      #1;
      wq.delete();
      m_cnt = 0;
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_stall", stall, 0);
      chk("rst_fwd_rs", fwd_rs_sel, 0);
      chk("rst_fwd_rt", fwd_rt_sel, 0);
      chk("rst_issue", issue, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 12, 1, 11, 1, 0, 0, 0, 0);
      chk("post_rst_fwd", obs_rs, 0);

      // random traffic on a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(7) != 0), 5'($urandom_range(7)), 1'($urandom),
               5'($urandom_range(7)), 1'($urandom), 1'($urandom),
               5'($urandom_range(7)), 1'($urandom), ($urandom_range(7) == 0));
      end

      // drive the counter into saturation
      for (int n = 0; n < CNT_MAX + 2; n++) begin
         cycle(1, 0, 0, 0, 0, 1, 9, 1, 0);
         for (int j = 0; j < DEPTH + 1; j++) cycle(1, 9, 1, 0, 0, 0, 0, 0, 0);
      end
      cycle(1, 0, 0, 0, 0, 1, 9, 1, 0);
      cycle(1, 9, 1, 0, 0, 0, 0, 0, 0);
      chk("cnt_saturated", obs_cnt, CNT_MAX);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
